// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every N_IN-bit vector, captures two responses, reports equivalence.
// Optional macro TT_SWEEP_STOP_ON_MISMATCH_EN ends the sweep at the first mismatching vector.
module truth_table_sweeper #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  resp_a,
    input  logic                  resp_b,
    output logic [N_IN-1:0]       stim,
    output logic                  busy,
    output logic                  done,
    output logic [(1<<N_IN)-1:0]  table_a,
    output logic [(1<<N_IN)-1:0]  table_b,
    output logic                  match,
    output logic [N_IN:0]         mm_cnt,
    output logic [N_IN-1:0]       first_mm
);

    localparam int unsigned NUM_VEC = 1 << N_IN;
    localparam int unsigned CNT_W   = N_IN + 1;
    localparam int unsigned SET_W   = 4;
    localparam logic [N_IN-1:0]  LAST_VEC   = N_IN'(NUM_VEC - 1);
    localparam logic [SET_W-1:0] SETTLE_END = SET_W'(SETTLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } stateT;

    stateT              state;
    stateT              stateNext;
    logic [SET_W-1:0]   settleCnt;
    logic [SET_W-1:0]   settleCntNext;

    logic [N_IN-1:0]    stimNext;
    logic               busyNext;
    logic               doneNext;
    logic [NUM_VEC-1:0] tableANext;
    logic [NUM_VEC-1:0] tableBNext;
    logic               matchNext;
    logic [CNT_W-1:0]   mmCntNext;
    logic [N_IN-1:0]    firstMmNext;

    logic               sampleNow;
    logic               mismatch;
    logic               lastVec;
    logic               stopNow;

    assign sampleNow = (state == SWEEP) && (settleCnt == SETTLE_END);
    assign mismatch  = resp_a ^ resp_b;
    assign lastVec   = (stim == LAST_VEC);

    // Sweep ends on the last vector, or optionally on the first mismatching sample.
    always_comb begin
        stopNow = lastVec;
`ifdef TT_SWEEP_STOP_ON_MISMATCH_EN
        stopNow = lastVec | mismatch;
`endif
    end

    // Next-state and next-output logic; every register holds unless a branch overrides it.
    always_comb begin
        stateNext     = state;
        settleCntNext = settleCnt;
        stimNext      = stim;
        busyNext      = busy;
        doneNext      = 1'b0;
        tableANext    = table_a;
        tableBNext    = table_b;
        matchNext     = match;
        mmCntNext     = mm_cnt;
        firstMmNext   = first_mm;

        case (state)
            IDLE: begin
                if (start) begin
                    stateNext     = SWEEP;
                    settleCntNext = '0;
                    stimNext      = '0;
                    busyNext      = 1'b1;
                    tableANext    = '0;
                    tableBNext    = '0;
                    matchNext     = 1'b0;
                    mmCntNext     = '0;
                    firstMmNext   = '0;
                end
            end

            SWEEP: begin
                if (sampleNow) begin
                    tableANext[stim] = resp_a;
                    tableBNext[stim] = resp_b;
                    if (mismatch) begin
                        mmCntNext = mm_cnt + CNT_W'(1);
                        if (mm_cnt == '0) begin
                            firstMmNext = stim;
                        end
                    end
                    if (stopNow) begin
                        stateNext = DONE;
                        busyNext  = 1'b0;
                        doneNext  = 1'b1;
                        matchNext = (mmCntNext == '0);
                    end else begin
                        stimNext      = stim + N_IN'(1);
                        settleCntNext = '0;
                    end
                end else begin
                    settleCntNext = settleCnt + SET_W'(1);
                end
            end

            DONE: begin
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            settleCnt <= '0;
            stim      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_a   <= '0;
            table_b   <= '0;
            match     <= 1'b0;
            mm_cnt    <= '0;
            first_mm  <= '0;
        end else begin
            state     <= stateNext;
            settleCnt <= settleCntNext;
            stim      <= stimNext;
            busy      <= busyNext;
            done      <= doneNext;
            table_a   <= tableANext;
            table_b   <= tableBNext;
            match     <= matchNext;
            mm_cnt    <= mmCntNext;
            first_mm  <= firstMmNext;
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: vector table, randomized sweeps and multi-cycle corner cases.
module tb_truth_table_sweeper;

    localparam int P3  = 2;
    localparam int NV3 = 8;
`ifdef TT_SWEEP_STOP_ON_MISMATCH_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        logic [7:0] ta;
        logic [7:0] tb;
        logic [7:0] eA;
        logic [7:0] eB;
        int         eMm;
        int         eFirst;
        bit         eMatch;
        int         eLat;
    } vecT;

    typedef struct {
        logic [63:0] tabA;
        logic [63:0] tabB;
        int          mm;
        int          first;
        bit          match;
        int          lat;
    } expT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start3, start1;
    logic [7:0] curTa, curTb;
    logic       resp3a, resp3b, resp1a, resp1b;

    logic [2:0] stim3;
    logic       busy3, done3, match3;
    logic [7:0] tableA3, tableB3;
    logic [3:0] mmCnt3;
    logic [2:0] firstMm3;

    logic [0:0] stim1;
    logic       busy1, done1, match1;
    logic [1:0] tableA1, tableB1;
    logic [1:0] mmCnt1;
    logic [0:0] firstMm1;

    int checks = 0;
    int failures = 0;

    assign resp3a = curTa[stim3];
    assign resp3b = curTb[stim3];
    assign resp1a = stim1[0];
    assign resp1b = 1'b0;

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .resp_a(resp3a), .resp_b(resp3b),
        .stim(stim3), .busy(busy3), .done(done3), .table_a(tableA3), .table_b(tableB3),
        .match(match3), .mm_cnt(mmCnt3), .first_mm(firstMm3)
    );

    truth_table_sweeper #(.N_IN(1), .SETTLE(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .resp_a(resp1a), .resp_b(resp1b),
        .stim(stim1), .busy(busy1), .done(done1), .table_a(tableA1), .table_b(tableB1),
        .match(match1), .mm_cnt(mmCnt1), .first_mm(firstMm1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: truth tables straight from the response functions, mismatch statistics by counting.
    function automatic expT model(input int nv, input int p, input logic [63:0] ta, input logic [63:0] tb);
        expT e;
        e.tabA = '0;
        e.tabB = '0;
        e.mm = 0;
        e.first = 0;
        e.lat = nv * p;
        for (int k = 0; k < nv; k++) begin
            e.tabA[k] = ta[k];
            e.tabB[k] = tb[k];
            if (ta[k] != tb[k]) begin
                if (e.mm == 0) e.first = k;
                e.mm++;
                if (STOP) begin
                    e.lat = (k + 1) * p;
                    break;
                end
            end
        end
        e.match = (e.mm == 0);
        return e;
    endfunction

    task automatic launch3();
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start3 = 1'b0;
    endtask

    // Counts edges after acceptance until done is seen, tracking busy and the stim schedule.
    task automatic waitDone3(input int pulseAt, output int lat, output bit busyOk, output bit stimOk);
        lat = 0;
        busyOk = 1'b1;
        stimOk = 1'b1;
        while (done3 !== 1'b1 && lat < 400) begin
            start3 = (lat == pulseAt);
            if (busy3 !== 1'b1) busyOk = 1'b0;
            if (int'(stim3) != lat / P3) stimOk = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start3 = 1'b0;
        if (busy3 !== 1'b0) busyOk = 1'b0;
    endtask

    task automatic checkRes3(input string tag, input expT e, input int lat, input bit busyOk, input bit stimOk);
        chk($sformatf("%s.table_a", tag), 64'(tableA3), e.tabA);
        chk($sformatf("%s.table_b", tag), 64'(tableB3), e.tabB);
        chk($sformatf("%s.mm_cnt", tag), 64'(mmCnt3), 64'(e.mm));
        chk($sformatf("%s.first_mm", tag), 64'(firstMm3), 64'(e.first));
        chk($sformatf("%s.match", tag), 64'(match3), 64'(e.match));
        chk($sformatf("%s.latency", tag), 64'(lat), 64'(e.lat));
        chk($sformatf("%s.busy", tag), 64'(busyOk), 64'd1);
        chk($sformatf("%s.stim_seq", tag), 64'(stimOk), 64'd1);
    endtask

    task automatic chkIdle3(input string tag);
        chk($sformatf("%s.stim", tag), 64'(stim3), 64'd0);
        chk($sformatf("%s.busy", tag), 64'(busy3), 64'd0);
        chk($sformatf("%s.done", tag), 64'(done3), 64'd0);
        chk($sformatf("%s.table_a", tag), 64'(tableA3), 64'd0);
        chk($sformatf("%s.table_b", tag), 64'(tableB3), 64'd0);
        chk($sformatf("%s.match", tag), 64'(match3), 64'd0);
        chk($sformatf("%s.mm_cnt", tag), 64'(mmCnt3), 64'd0);
        chk($sformatf("%s.first_mm", tag), 64'(firstMm3), 64'd0);
    endtask

    vecT vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bit busyOk, stimOk;
        int n;
        expT e;
        logic [7:0] ta, tb;

`ifdef TT_SWEEP_STOP_ON_MISMATCH_EN
        vecs[0] = '{8'h67, 8'h67, 8'h67, 8'h67, 0, 0, 1'b1, 16};
        vecs[1] = '{8'h67, 8'h0F, 8'h07, 8'h0F, 1, 3, 1'b0, 8};
        vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'h01, 1, 0, 1'b0, 2};
        vecs[3] = '{8'hA5, 8'hA4, 8'h01, 8'h00, 1, 0, 1'b0, 2};
        vecs[4] = '{8'h0F, 8'h8F, 8'h0F, 8'h8F, 1, 7, 1'b0, 16};
`else
        vecs[0] = '{8'h67, 8'h67, 8'h67, 8'h67, 0, 0, 1'b1, 16};
        vecs[1] = '{8'h67, 8'h0F, 8'h67, 8'h0F, 3, 3, 1'b0, 16};
        vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8, 0, 1'b0, 16};
        vecs[3] = '{8'hA5, 8'hA4, 8'hA5, 8'hA4, 1, 0, 1'b0, 16};
        vecs[4] = '{8'h0F, 8'h8F, 8'h0F, 8'h8F, 1, 7, 1'b0, 16};
`endif

        rst = 1'b1;
        start3 = 1'b0;
        start1 = 1'b0;
        curTa = '0;
        curTb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chkIdle3("reset");
        chk("reset.dut1_busy", 64'(busy1), 64'd0);
        chk("reset.dut1_table_a", 64'(tableA1), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            curTa = vecs[i].ta;
            curTb = vecs[i].tb;
            launch3();
            waitDone3(-1, lat, busyOk, stimOk);
            e.tabA = 64'(vecs[i].eA);
            e.tabB = 64'(vecs[i].eB);
            e.mm = vecs[i].eMm;
            e.first = vecs[i].eFirst;
            e.match = vecs[i].eMatch;
            e.lat = vecs[i].eLat;
            checkRes3($sformatf("vec%0d", i), e, lat, busyOk, stimOk);
        end

        for (int r = 0; r < 20; r++) begin
            ta = 8'($urandom);
            tb = ($urandom_range(0, 2) == 0) ? ta : 8'($urandom);
            curTa = ta;
            curTb = tb;
            launch3();
            waitDone3(-1, lat, busyOk, stimOk);
            checkRes3($sformatf("rand%0d", r), model(NV3, P3, 64'(ta), 64'(tb)), lat, busyOk, stimOk);
        end

        // start pulsed mid-sweep and held through done: no effect, then accepted after done.
        curTa = 8'h67;
        curTb = 8'h67;
        launch3();
        waitDone3(5, lat, busyOk, stimOk);
        checkRes3("ignore", model(NV3, P3, 64'h67, 64'h67), lat, busyOk, stimOk);
        start3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("restart.idle_busy", 64'(busy3), 64'd0);
        chk("restart.idle_done", 64'(done3), 64'd0);
        chk("restart.idle_hold_table", 64'(tableA3), 64'h67);
        @(posedge clk);
        @(negedge clk);
        start3 = 1'b0;
        chk("restart.accept_busy", 64'(busy3), 64'd1);
        chk("restart.accept_stim", 64'(stim3), 64'd0);
        chk("restart.accept_clear", 64'(tableA3), 64'd0);
        waitDone3(-1, lat, busyOk, stimOk);
        checkRes3("restart", model(NV3, P3, 64'h67, 64'h67), lat, busyOk, stimOk);

        // Reset mid-sweep when stim reaches 4.
        curTb = 8'h0F;
        launch3();
        n = 0;
        while (stim3 != 3'd4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid.reached4", 64'(stim3), 64'd4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chkIdle3("rstmid");
        @(posedge clk);
        @(negedge clk);
        chk("rstmid.stays_idle", 64'(busy3), 64'd0);
        curTb = 8'h67;
        launch3();
        waitDone3(-1, lat, busyOk, stimOk);
        checkRes3("after_rst", model(NV3, P3, 64'h67, 64'h67), lat, busyOk, stimOk);

        // rst and start on the same edge: reset wins.
        @(negedge clk);
        rst = 1'b1;
        start3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start3 = 1'b0;
        chkIdle3("rst_start");
        @(posedge clk);
        @(negedge clk);
        chk("rst_start.idle", 64'(busy3), 64'd0);

        // N_IN=1, SETTLE=0: stim advances each cycle.
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        busyOk = 1'b1;
        stimOk = 1'b1;
        while (done1 !== 1'b1 && lat < 50) begin
            if (busy1 !== 1'b1) busyOk = 1'b0;
            if (int'(stim1) != lat) stimOk = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        e = model(2, 1, 64'h2, 64'h0);
        chk("n1.table_a", 64'(tableA1), e.tabA);
        chk("n1.table_b", 64'(tableB1), e.tabB);
        chk("n1.mm_cnt", 64'(mmCnt1), 64'(e.mm));
        chk("n1.first_mm", 64'(firstMm1), 64'(e.first));
        chk("n1.match", 64'(match1), 64'(e.match));
        chk("n1.latency", 64'(lat), 64'(e.lat));
        chk("n1.busy", 64'(busyOk), 64'd1);
        chk("n1.stim_seq", 64'(stimOk), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("n1.done_pulse", 64'(done1), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
